uart_rx_fsm: RTL and testbench

Frame sequencer for the UART receive path. It detects the falling edge of the start bit and owns the oversampling edge counter and the bit counter. It drives the enables for the data sampler, start/parity/stop checkers and deserializer, and issues a one-cycle data_valid or error pulse per frame. It sits between rx_in and the checker/deserializer blocks in the UART RX top.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_fsm_edge_bit_counter.sv | 50 +++++
 rtl/uart_rx_fsm.sv | 136 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared state encoding, constants and window helper for the UART receive frame sequencer.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int PRESC_MIN  = 8;
   localparam int DATA_W_DEF = 8;

   // First edge of the check window: the sampler's majority output settles two edges past mid-bit.
   function automatic logic [15:0] win_start(input logic [15:0] p);
      return (p >> 1) + 16'd2;
   endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Edge-within-bit and bit-within-frame counters; advance every cycle while en_i, wrap at p_i-1.
// clr_i or a low en_i zeroes both counters on the next edge; no backpressure.
module edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [PRESC_W-1:0] p_i,
   output logic [PRESC_W-1:0] edge_cnt_o,
   output logic [3:0]         bit_cnt_o,
   output logic               wrap_o
);

   logic [PRESC_W-1:0] edge_q, edge_d;
   logic [3:0]         bit_q, bit_d;

   assign wrap_o = en_i && (edge_q == (p_i - PRESC_W'(1)));

   always_comb begin
      edge_d = edge_q;
      bit_d  = bit_q;
      if (!en_i || clr_i) begin
         edge_d = '0;
         bit_d  = '0;
      end else if (wrap_o) begin
         edge_d = '0;
         bit_d  = bit_q + 4'd1;
      end else begin
         edge_d = edge_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else begin
         edge_q <= edge_d;
         bit_q  <= bit_d;
      end
   end

   assign edge_cnt_o = edge_q;
   assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start detect, bit timing, checker/sampler enables, one pulse per frame.
// Pulses land one cycle after the final stop-bit edge; enables are decoded from registered state.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_in,
   input  logic               par_en,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               start_err,
   input  logic               par_err,
   input  logic               stop_err,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic [3:0]         bit_cnt,
   output logic               dat_samp_en,
   output logic               start_check_en,
   output logic               par_check_en,
   output logic               stop_check_en,
   output logic               deser_en,
   output logic               data_valid,
   output logic               frame_err,
   output logic               parity_err,
   output logic               busy
);

   rx_state_e          state_q, state_d;
   logic [PRESC_W-1:0] p_q, p_d;
   logic               par_flag_q, par_flag_d;
   logic               data_valid_q, data_valid_d;
   logic               frame_err_q, frame_err_d;
   logic               parity_err_q, parity_err_d;

   logic               cnt_en;
   logic               cnt_clr;
   logic               start_entry;
   logic               wrap;
   logic [PRESC_W-1:0] win_lo;
   logic               in_win;

   assign cnt_en = (state_q != IDLE);

   edge_bit_counter #(
      .PRESC_W (PRESC_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .en_i       (cnt_en),
      .clr_i      (cnt_clr),
      .p_i        (p_q),
      .edge_cnt_o (edge_cnt),
      .bit_cnt_o  (bit_cnt),
      .wrap_o     (wrap)
   );

   assign win_lo = PRESC_W'(win_start(16'(p_q)));
   assign in_win = (edge_cnt >= win_lo);

   always_comb begin
      state_d      = state_q;
      p_d          = p_q;
      par_flag_d   = par_flag_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      start_entry  = 1'b0;
      cnt_clr      = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_in) state_d = START;
         end
         START: begin
            if (wrap) state_d = start_err ? IDLE : DATA;
         end
         DATA: begin
            if (wrap && (bit_cnt == 4'(DATA_W))) state_d = par_en ? PARITY : STOP;
         end
         PARITY: begin
            if (wrap) begin
               par_flag_d = par_err;
               state_d    = STOP;
            end
         end
         STOP: begin
            if (wrap) begin
               // Parity failure outranks a bad stop bit; exactly one pulse per frame.
               parity_err_d = par_flag_q;
               frame_err_d  = !par_flag_q && stop_err;
               data_valid_d = !par_flag_q && !stop_err;
               state_d      = rx_in ? IDLE : START;
            end
         end
         default: state_d = IDLE;
      endcase

      start_entry = (state_d == START) && (state_q != START);
      if (start_entry) begin
         p_d        = prescale;
         par_flag_d = 1'b0;
      end
      cnt_clr = start_entry || (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         p_q          <= '0;
         par_flag_q   <= 1'b0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         par_flag_q   <= par_flag_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign busy           = (state_q != IDLE);
   assign dat_samp_en    = busy;
   assign start_check_en = (state_q == START)  && in_win;
   assign par_check_en   = (state_q == PARITY) && in_win;
   assign stop_check_en  = (state_q == STOP)   && in_win;
   assign deser_en       = (state_q == DATA)   && (edge_cnt == win_lo);
   assign data_valid     = data_valid_q;
   assign frame_err      = frame_err_q;
   assign parity_err     = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed + randomized frames against a timeline model of the UART RX sequencer.
module tb_uart_rx_fsm;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_in;
   logic          par_en;
   logic [PW-1:0] prescale;
   logic          start_err, par_err, stop_err;
   logic          glitch_f, par_bad_f, stop_bad_f;
   logic [PW-1:0] edge_cnt;
   logic [3:0]    bit_cnt;
   logic          dat_samp_en, start_check_en, par_check_en, stop_check_en;
   logic          deser_en, data_valid, frame_err, parity_err, busy;
   logic [18:0]   obs;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Checker stand-ins: an error is only visible while its enable is high.
   assign start_err = start_check_en & glitch_f;
   assign par_err   = par_check_en & par_bad_f;
   assign stop_err  = stop_check_en & stop_bad_f;

   uart_rx_fsm #(
      .DATA_W  (DW),
      .PRESC_W (PW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_in          (rx_in),
      .par_en         (par_en),
      .prescale       (prescale),
      .start_err      (start_err),
      .par_err        (par_err),
      .stop_err       (stop_err),
      .edge_cnt       (edge_cnt),
      .bit_cnt        (bit_cnt),
      .dat_samp_en    (dat_samp_en),
      .start_check_en (start_check_en),
      .par_check_en   (par_check_en),
      .stop_check_en  (stop_check_en),
      .deser_en       (deser_en),
      .data_valid     (data_valid),
      .frame_err      (frame_err),
      .parity_err     (parity_err),
      .busy           (busy)
   );

   assign obs = {busy, dat_samp_en, start_check_en, par_check_en, stop_check_en, deser_en,
                 data_valid, frame_err, parity_err, edge_cnt, bit_cnt};

   task automatic check(input string tag, input int k, input logic [18:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int rand_p();
      case ($urandom_range(0, 2))
         0:       return 8;
         1:       return 16;
         default: return 32;
      endcase
   endfunction

   // Expected outputs k cycles after START entry, from the bit timeline alone.
   function automatic logic [18:0] exp_vec(input int p, input bit pe, input bit gl, input int k,
                                           input logic [2:0] pulses);
      int h, e, b, last;
      logic inw;
      logic [5:0] e6;
      logic [3:0] b4;
      h    = p / 2;
      e    = k % p;
      b    = k / p;
      last = gl ? 0 : DW + 1 + int'(pe);
      inw  = (e >= h + 2);
      e6   = e[5:0];
      b4   = b[3:0];
      return {1'b1, 1'b1, (b == 0) && inw, pe && (b == DW + 1) && inw, !gl && (b == last) && inw,
              (b >= 1) && (b <= DW) && (e == h + 2), pulses, e6, b4};
   endfunction

   task automatic run_frame(input int p, input bit pe, input logic [7:0] data, input bit gl,
                            input bit pbad, input bit sbad, input bit b2b, input int next_p,
                            input logic [2:0] first_pulse, input int abort_k,
                            output logic [2:0] end_pulse);
      int nb, len, b, deser_seen;
      logic lvl;
      nb         = gl ? 1 : DW + 2 + int'(pe);
      len        = nb * p;
      deser_seen = 0;
      end_pulse  = gl ? 3'b000 : (pe && pbad) ? 3'b001 : sbad ? 3'b010 : 3'b100;
      for (int k = 0; k < len; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            glitch_f   = gl;
            par_bad_f  = pbad;
            stop_bad_f = sbad;
            par_en     = pe;
         end
         b = k / p;
         if (gl)                      lvl = (k >= 2);
         else if (b == 0)             lvl = 1'b0;
         else if (b <= DW)            lvl = data[b-1];
         else if (pe && b == DW + 1)  lvl = (^data) ^ pbad;
         else                         lvl = !sbad;
         if (b2b && k == len - 1) begin
            lvl      = 1'b0;
            prescale = PW'(next_p);
         end else if (k == 1) begin
            prescale = PW'(rand_p());
         end
         rx_in = lvl;
         @(negedge clk);
         check("frame", k, exp_vec(p, pe, gl, k, (k == 0) ? first_pulse : 3'b000));
         deser_seen += int'(deser_en);
         if (k == abort_k) begin
            #2 rst = 1'b0;
            #1;
            check("rst_async", k, '0);
            return;
         end
      end
      check_int("deser_count", deser_seen, gl ? 0 : DW);
   endtask

   task automatic start_from_idle(input int p);
      @(posedge clk);
      #1;
      prescale = PW'(p);
      rx_in    = 1'b0;
   endtask

   task automatic tail(input logic [2:0] pulse);
      @(posedge clk);
      #1;
      rx_in = 1'b1;
      @(negedge clk);
      check("pulse", 0, {6'b0, pulse, 10'b0});
      @(posedge clk);
      #1;
      @(negedge clk);
      check("idle", 1, '0);
   endtask

   initial begin
      logic [2:0] pend, endp;
      int p_cur, p_nxt;
      bit pe, gl, pbad, sbad, b2b, b2b_prev;
      logic [7:0] d;

      rst = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = PW'(8);
      glitch_f = 1'b0; par_bad_f = 1'b0; stop_bad_f = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", 0, '0);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("idle_after_reset", 0, '0);

      // P=8, no parity, 0xA5: data_valid 80 cycles after entry.
      start_from_idle(8);
      run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8, 3'b000, -1, endp);
      tail(endp);

      // P=16 with parity error.
      start_from_idle(16);
      run_frame(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 16, 3'b000, -1, endp);
      tail(endp);

      // Bad stop bit holds rx low: frame_err, then immediate next START.
      start_from_idle(8);
      run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8, 3'b000, -1, endp);
      run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8, endp, -1, endp);
      tail(endp);

      // Start glitch.
      start_from_idle(8);
      run_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8, 3'b000, -1, endp);
      tail(endp);

      // Back-to-back at P=32.
      start_from_idle(32);
      run_frame(32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32, 3'b000, -1, endp);
      run_frame(32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 32, endp, -1, endp);
      tail(endp);

      // Reset mid data bit 4, then a clean frame.
      start_from_idle(16);
      run_frame(16, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 16, 3'b000, 4 * 16 + 3, endp);
      rx_in = 1'b1; glitch_f = 1'b0; par_bad_f = 1'b0; stop_bad_f = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("idle_after_midframe_reset", 0, '0);
      start_from_idle(8);
      run_frame(8, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8, 3'b000, -1, endp);
      tail(endp);

      // Randomized frames.
      pend     = 3'b000;
      b2b_prev = 1'b0;
      p_cur    = rand_p();
      for (int i = 0; i < 12; i++) begin
         p_nxt = rand_p();
         pe    = 1'($urandom_range(0, 1));
         d     = 8'($urandom);
         gl    = ($urandom_range(0, 5) == 0);
         pbad  = 1'($urandom_range(0, 1));
         sbad  = !gl && (i < 11) && ($urandom_range(0, 3) == 0);
         b2b   = !gl && (i < 11) && (sbad || ($urandom_range(0, 1) == 1));
         if (!b2b_prev) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            start_from_idle(p_cur);
         end
         run_frame(p_cur, pe, d, gl, pbad, sbad, b2b, p_nxt, pend, -1, endp);
         if (b2b) begin
            pend = endp;
         end else begin
            tail(endp);
            pend = 3'b000;
         end
         b2b_prev = b2b;
         p_cur    = p_nxt;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
